// File: rtl/mms_stream.sv
// mms_stream: streaming max/min of COUNT-number frames; `define MMS_INDEX_EN adds result_idx
module mms_stream #(
  parameter int WIDTH = 8,
  parameter int COUNT = 8,
  localparam int CW = $clog2(COUNT + 1),
  localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             select,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] number,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [7:0]       frame_cnt
`ifdef MMS_INDEX_EN
  ,
  output logic [IW-1:0]    result_idx
`endif
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic sel_q, sel_use, xfer, first, take, last, better;
  assign in_ready  = (state == DONE) ? out_ready : 1'b1;
  assign out_valid = (state == DONE);
  assign xfer      = in_valid && in_ready;
  // a transfer outside ACC opens a new frame, including the one overlapping a DONE handshake
  assign first     = xfer && (state != ACC);
  assign take      = (state == DONE) && out_ready;
  assign sel_use   = first ? select : sel_q;
  assign better    = sel_use ? (number < acc) : (number > acc);
  assign acc_nx    = (first || better) ? number : acc;
  assign cnt_nx    = first ? CW'(1) : cnt + CW'(1);
  assign last      = xfer && (cnt_nx == CW'(COUNT));
  always_comb begin
    state_nx = state;
    state_nx = last ? DONE : xfer ? ACC : take ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sel_q     <= 1'b0;
      result    <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_nx;
      if (xfer) begin
        acc <= acc_nx;
        cnt <= last ? '0 : cnt_nx;
      end
      if (first) sel_q <= select;
      if (last) result <= acc_nx;
      if (take) frame_cnt <= frame_cnt + 8'd1;
    end
  end
`ifdef MMS_INDEX_EN
  logic [IW-1:0] acc_idx, idx_nx;
  assign idx_nx = first ? '0 : better ? cnt[IW-1:0] : acc_idx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_idx    <= '0;
      result_idx <= '0;
    end else begin
      if (xfer) acc_idx <= idx_nx;
      if (last) result_idx <= idx_nx;
    end
  end
`endif
endmodule

// File: tb/tb_mms_stream.sv
// tb_mms_stream: randomized and directed checks of mms_stream against a frame-level reference model
module tb_mms_stream;
  localparam int N = 8;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;
  logic select = 0, in_valid = 0, out_ready = 0;
  logic [7:0] number = 0;
  logic in_ready, out_valid;
  logic [7:0] result, frame_cnt;
  logic a_in_valid = 0, a_out_ready = 1, a_in_ready, a_out_valid;
  logic [15:0] a_number = 0, a_result;
  logic [7:0] a_frame_cnt;
  logic b_select = 0, b_in_valid = 0, b_out_ready = 1, b_in_ready, b_out_valid;
  logic [7:0] b_number = 0, b_result, b_frame_cnt;
`ifdef MMS_INDEX_EN
  logic [2:0] result_idx;
  logic [0:0] a_result_idx;
  logic [9:0] b_result_idx;
`endif
  mms_stream #(.WIDTH(8), .COUNT(N)) dut (
    .clk(clk), .reset(reset), .select(select), .in_valid(in_valid), .in_ready(in_ready),
    .number(number), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .frame_cnt(frame_cnt)
`ifdef MMS_INDEX_EN
    , .result_idx(result_idx)
`endif
  );
  mms_stream #(.WIDTH(16), .COUNT(1)) u1 (
    .clk(clk), .reset(reset), .select(1'b0), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .number(a_number), .out_valid(a_out_valid), .out_ready(a_out_ready), .result(a_result),
    .frame_cnt(a_frame_cnt)
`ifdef MMS_INDEX_EN
    , .result_idx(a_result_idx)
`endif
  );
  mms_stream #(.WIDTH(8), .COUNT(1024)) u2 (
    .clk(clk), .reset(reset), .select(b_select), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .number(b_number), .out_valid(b_out_valid), .out_ready(b_out_ready), .result(b_result),
    .frame_cnt(b_frame_cnt)
`ifdef MMS_INDEX_EN
    , .result_idx(b_result_idx)
`endif
  );
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // frame-level model: collect accepted numbers, pick the extremum once the frame is full
  logic [7:0] q[$];
  logic m_sel = 0;
  bit m_valid = 0, fire;
  logic [7:0] m_res = 0, m_fcnt = 0;
  int m_idx = 0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_valid = 0;
      m_res = 0;
      m_fcnt = 0;
      m_idx = 0;
      m_sel = 0;
    end else begin
      fire = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) begin
        m_valid = 0;
        m_fcnt++;
      end
      if (fire) begin
        if (q.size() == 0) m_sel = select;
        q.push_back(number);
        if (q.size() == N) begin
          m_res = q[0];
          m_idx = 0;
          for (int i = 1; i < N; i++)
            if (m_sel ? (q[i] < m_res) : (q[i] > m_res)) begin
              m_res = q[i];
              m_idx = i;
            end
          m_valid = 1;
          q.delete();
        end
      end
    end
  end
  always @(negedge clk) begin
    if (reset) begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("result", result, m_res);
      chk("frame_cnt", frame_cnt, m_fcnt);
`ifdef MMS_INDEX_EN
      chk("result_idx", result_idx, m_idx);
`endif
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic feed(input logic [7:0] n, input logic s);
    in_valid = 1;
    number = n;
    select = s;
    step();
    in_valid = 0;
  endtask
  logic [7:0] v[8];
  logic [7:0] d[1024];
  logic [7:0] best;
  int bi;
  initial begin
    repeat (3) step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1;
    step();
    v = '{3, 200, 17, 200, 0, 255, 9, 1};
    for (int i = 0; i < 8; i++) feed(v[i], 1'b0);
    chk("f1_valid", out_valid, 1);
    chk("f1_result", result, 255);
    chk("f1_model", m_res, 255);
`ifdef MMS_INDEX_EN
    chk("f1_idx", result_idx, 5);
`endif
    repeat (5) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 255);
      chk("bp_frame_cnt", frame_cnt, 0);
    end
    out_ready = 1;
    feed(8'h80, 1'b0);
    chk("b2b_frame_cnt", frame_cnt, 1);
    chk("b2b_valid_drop", out_valid, 0);
    for (int i = 1; i < 8; i++) feed(8'h80, 1'b0);
    chk("f2_result", result, 8'h80);
    step();
    chk("f2_frame_cnt", frame_cnt, 2);
    v = '{40, 7, 7, 90, 7, 12, 8, 100};
    for (int i = 0; i < 8; i++) feed(v[i], (i == 0) ? 1'b1 : i[0]);
    chk("min_result", result, 7);
    chk("min_model", m_res, 7);
`ifdef MMS_INDEX_EN
    chk("min_idx", result_idx, 1);
`endif
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("stall_no_early_valid", out_valid, 0);
      feed(8'((i + 1) * 10), 1'b0);
      if (i % 3 == 0 && i != 7) repeat (2) step();
    end
    chk("stall_result", result, 80);
    chk("stall_valid", out_valid, 1);
    step();
    chk("stall_valid_once", out_valid, 0);
    for (int i = 0; i < 4; i++) feed(8'(i + 100), 1'b0);
    #3 reset = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    @(posedge clk);
    #1 reset = 1;
    v = '{5, 3, 8, 1, 7, 2, 6, 4};
    for (int i = 0; i < 8; i++) feed(v[i], 1'b1);
    chk("post_rst_result", result, 1);
`ifdef MMS_INDEX_EN
    chk("post_rst_idx", result_idx, 3);
`endif
    step();
    repeat (800) begin
      in_valid = $urandom_range(0, 3) != 0;
      number = 8'($urandom);
      select = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid = 0;
    out_ready = 1;
    repeat (3) step();
    a_in_valid = 1;
    a_number = 16'hBEEF;
    step();
    a_in_valid = 0;
    chk("c1_valid", a_out_valid, 1);
    chk("c1_result", a_result, 16'hBEEF);
`ifdef MMS_INDEX_EN
    chk("c1_idx", a_result_idx, 0);
`endif
    step();
    chk("c1_valid_drop", a_out_valid, 0);
    chk("c1_frame_cnt", a_frame_cnt, 1);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1024; i++) d[i] = 8'($urandom_range(1, 254));
      best = d[0];
      bi = 0;
      for (int i = 1; i < 1024; i++)
        if (s == 1 ? (d[i] < best) : (d[i] > best)) begin
          best = d[i];
          bi = i;
        end
      b_select = 1'(s);
      for (int i = 0; i < 1024; i++) begin
        if (i == 1023) chk("c1024_no_early_valid", b_out_valid, 0);
        b_in_valid = 1;
        b_number = d[i];
        step();
        b_select = ~b_select;
      end
      b_in_valid = 0;
      chk("c1024_valid", b_out_valid, 1);
      chk("c1024_result", b_result, best);
`ifdef MMS_INDEX_EN
      chk("c1024_idx", b_result_idx, bi);
`endif
      step();
      chk("c1024_frame_cnt", b_frame_cnt, s + 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule
